// File: rtl/defines.sv
// Shared types and constants for the iterative divider and the issue-stage interface.
package defines;

  localparam int REG_WIDTH      = 5;
  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_control_t;

  typedef struct packed {
    div_control_t         div_control;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
  } ix_div_inf_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_DIVIDE,
    DIV_FIXUP,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor.
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] trial;

  // The extra top bit keeps the borrow visible even when rem_in has its MSB set.
  assign trial   = {1'b0, rem_in, dividend_msb} - {2'b00, divisor};
  assign q_bit   = ~trial[XLEN+1];
  assign rem_out = q_bit ? trial[XLEN-1:0] : {rem_in[XLEN-2:0], dividend_msb};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) with flush and write-back handshake.
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration loop for trivial operands.
module div_unit
  import defines::*;
#(
  parameter int XLEN           = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ix_div_valid,
  input  ix_div_inf_t          ix_div_inf,
  input  logic                 wb_do_branch,
  output logic                 div_wb_valid,
  output logic [REG_WIDTH-1:0] div_wb_rd,
  output logic [XLEN-1:0]      div_wb_result,
  input  logic                 wb_div_ready,
  output logic                 div_ix_done
);

  localparam int CNT_W = $clog2(DIV_ITERATIONS);

  generate
    if (ITER_PER_CYCLE != 1) begin : g_iter_check
      $error("div_unit: only ITER_PER_CYCLE=1 is supported");
    end
  endgenerate

  div_state_t           state_q, state_d;
  logic [REG_WIDTH-1:0] rd_q, rd_d;
  logic                 rem_sel_q, rem_sel_d;
  logic [XLEN-1:0]      dividend_q, dividend_d;
  logic [XLEN-1:0]      divisor_q, divisor_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_result_q, wb_result_d;
  logic                 ix_done_q, ix_done_d;

  logic            is_signed, accept, div_by_zero, flush, early_out;
  logic [XLEN-1:0] abs_a, abs_b, step_rem;
  logic            step_q;

  assign is_signed   = ~ix_div_inf.div_control[0];
  assign abs_a       = (is_signed & ix_div_inf.rs1[31]) ? -ix_div_inf.rs1 : ix_div_inf.rs1;
  assign abs_b       = (is_signed & ix_div_inf.rs2[31]) ? -ix_div_inf.rs2 : ix_div_inf.rs2;
  assign div_by_zero = (ix_div_inf.rs2 == '0);
  assign accept      = ix_div_valid & ~wb_do_branch & (state_q == DIV_IDLE);
  assign flush       = wb_do_branch & (state_q != DIV_IDLE);

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_quo, early_rem;

  // Priority mirrors what the full loop would produce for each trivial case.
  always_comb begin
    early_out = 1'b1;
    early_quo = '0;
    early_rem = abs_a;
    if (div_by_zero) begin
      early_quo = '1;
    end else if (abs_b == XLEN'(1)) begin
      early_quo = abs_a;
      early_rem = '0;
    end else if (abs_a < abs_b) begin
      early_quo = '0;
    end else begin
      early_out = 1'b0;
    end
  end
`else
  assign early_out = 1'b0;
`endif

  div_restoring_step #(.XLEN(XLEN)) u_step (
    .rem_in       (rem_q),
    .dividend_msb (dividend_q[XLEN-1]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      rd_q        <= '0;
      rem_sel_q   <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_result_q <= '0;
      ix_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rem_sel_q   <= rem_sel_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_result_q <= wb_result_d;
      ix_done_q   <= ix_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE:   if (accept) state_d = early_out ? DIV_FIXUP : DIV_DIVIDE;
        DIV_DIVIDE: if (cnt_q == '0) state_d = DIV_FIXUP;
        DIV_FIXUP:  state_d = DIV_DONE;
        DIV_DONE:   if (wb_div_ready) state_d = DIV_IDLE;
        default:    state_d = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d        = rd_q;
    rem_sel_d   = rem_sel_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_result_d = wb_result_q;
    ix_done_d   = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          rd_d       = ix_div_inf.rd;
          rem_sel_d  = ix_div_inf.div_control[1];
          dividend_d = abs_a;
          divisor_d  = abs_b;
          // Quotient stays all-ones on divide by zero; remainder sign restores rs1.
          q_neg_d    = is_signed & (ix_div_inf.rs1[31] ^ ix_div_inf.rs2[31]) & ~div_by_zero;
          r_neg_d    = is_signed & ix_div_inf.rs1[31];
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CNT_W'(DIV_ITERATIONS - 1);
`ifdef DIV_EARLY_OUT_EN
          if (early_out) begin
            quo_d = early_quo;
            rem_d = early_rem;
          end
`endif
        end
      end
      DIV_DIVIDE: begin
        rem_d      = step_rem;
        quo_d      = {quo_q[XLEN-2:0], step_q};
        dividend_d = dividend_q << 1;
        cnt_d      = cnt_q - CNT_W'(1);
      end
      DIV_FIXUP: begin
        if (rem_sel_q) wb_result_d = r_neg_q ? -rem_q : rem_q;
        else           wb_result_d = q_neg_q ? -quo_q : quo_q;
        wb_rd_d    = rd_q;
        wb_valid_d = 1'b1;
      end
      DIV_DONE: begin
        if (wb_div_ready) begin
          wb_valid_d = 1'b0;
          ix_done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (flush) begin
      wb_valid_d = 1'b0;
      ix_done_d  = 1'b0;
    end
  end

  assign div_wb_valid  = wb_valid_q;
  assign div_wb_rd     = wb_rd_q;
  assign div_wb_result = wb_result_q;
  assign div_ix_done   = ix_done_q;

`ifndef SYNTHESIS
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (rst)
    !(ix_div_valid && state_q != DIV_IDLE));
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expected latencies follow DIV_EARLY_OUT_EN.
module tb_div_unit;
  import defines::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ix_div_valid;
  ix_div_inf_t          ix_div_inf;
  logic                 wb_do_branch;
  logic                 div_wb_valid;
  logic [REG_WIDTH-1:0] div_wb_rd;
  logic [31:0]          div_wb_result;
  logic                 wb_div_ready;
  logic                 div_ix_done;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct packed {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  div_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ix_div_valid  (ix_div_valid),
    .ix_div_inf    (ix_div_inf),
    .wb_do_branch  (wb_do_branch),
    .div_wb_valid  (div_wb_valid),
    .div_wb_rd     (div_wb_rd),
    .div_wb_result (div_wb_result),
    .wb_div_ready  (wb_div_ready),
    .div_ix_done   (div_ix_done)
  );

  always #5 clk = ~clk;

  // Cycles from the request cycle until div_wb_valid is first seen.
  function automatic int exp_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] aa, bb;
    aa = (!c[0] && a[31]) ? -a : a;
    bb = (!c[0] && b[31]) ? -b : b;
    if (bb == 32'd0 || bb == 32'd1 || aa < bb) return 2;
`endif
    return 34;
  endfunction

  // Called at a negedge; presents the request for exactly one rising edge.
  task automatic issue(input logic [1:0] c, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    ix_div_inf.div_control = div_control_t'(c);
    ix_div_inf.rd          = rd;
    ix_div_inf.rs1         = a;
    ix_div_inf.rs2         = b;
    ix_div_valid           = 1'b1;
    @(negedge clk);
    ix_div_valid           = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!div_wb_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    check_cnt++;
    if ({div_wb_valid, div_ix_done, div_wb_rd, div_wb_result} !== '0)
      $display("[TB] FAIL reset_outputs got v=%b d=%b rd=%h res=%h expected all zero",
               div_wb_valid, div_ix_done, div_wb_rd, div_wb_result);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({div_wb_valid, div_ix_done} !== 2'b00)
      $display("[TB] FAIL idle_after_reset got v=%b d=%b expected 0 0", div_wb_valid, div_ix_done);
    else pass_cnt++;
  endtask

  task automatic test_arith();
    vec_t vecs [18];
    int   lat;
    vecs = '{
      '{2'b01, 32'd100,        32'd7,          32'd14},
      '{2'b11, 32'd100,        32'd7,          32'd2},
      '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD},
      '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF},
      '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000},
      '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000},
      '{2'b00, 32'd20,         32'hFFFFFFFA,   32'hFFFFFFFD},
      '{2'b10, 32'd20,         32'hFFFFFFFA,   32'd2},
      '{2'b01, 32'hFFFFFFFF,   32'h80000001,   32'd1},
      '{2'b11, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE},
      '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF},
      '{2'b10, 32'd5,          32'd0,          32'd5},
      '{2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF},
      '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB},
      '{2'b01, 32'd3,          32'd9,          32'd0},
      '{2'b11, 32'd3,          32'd9,          32'd3},
      '{2'b00, 32'hFFFFFFF9,   32'd1,          32'hFFFFFFF9},
      '{2'b10, 32'hFFFFFFF9,   32'hFFFFFFFF,   32'd0}
    };
    wb_div_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].c, 5'(i + 1), vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check_cnt++;
      if (lat !== exp_lat(vecs[i].c, vecs[i].a, vecs[i].b))
        $display("[TB] FAIL latency[%0d] got %0d expected %0d", i, lat, exp_lat(vecs[i].c, vecs[i].a, vecs[i].b));
      else pass_cnt++;
      check_cnt++;
      if (div_wb_result !== vecs[i].e || div_wb_rd !== 5'(i + 1))
        $display("[TB] FAIL result[%0d] got res=%h rd=%0d expected res=%h rd=%0d",
                 i, div_wb_result, div_wb_rd, vecs[i].e, i + 1);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if ({div_ix_done, div_wb_valid} !== 2'b10)
        $display("[TB] FAIL done_pulse[%0d] got d=%b v=%b expected d=1 v=0", i, div_ix_done, div_wb_valid);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (div_ix_done !== 1'b0)
        $display("[TB] FAIL done_single[%0d] got %b expected 0", i, div_ix_done);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    wb_div_ready = 1'b0;
    issue(2'b01, 5'd7, 32'd1000, 32'd10);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check_cnt++;
      if ({div_wb_valid, div_ix_done, div_wb_rd, div_wb_result} !== {1'b1, 1'b0, 5'd7, 32'd100})
        $display("[TB] FAIL hold[%0d] got v=%b d=%b rd=%0d res=%h expected v=1 d=0 rd=7 res=64",
                 i, div_wb_valid, div_ix_done, div_wb_rd, div_wb_result);
      else pass_cnt++;
      @(negedge clk);
    end
    wb_div_ready = 1'b1;
    @(negedge clk);
    wb_div_ready = 1'b0;
    check_cnt++;
    if ({div_ix_done, div_wb_valid} !== 2'b10)
      $display("[TB] FAIL bp_done got d=%b v=%b expected d=1 v=0", div_ix_done, div_wb_valid);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (div_ix_done !== 1'b0)
      $display("[TB] FAIL bp_done_single got %b expected 0", div_ix_done);
    else pass_cnt++;
    wb_div_ready = 1'b1;
  endtask

  task automatic check_followup(input string name);
    int lat;
    issue(2'b01, 5'd3, 32'd9, 32'd3);
    wait_valid(lat);
    check_cnt++;
    if (lat !== exp_lat(2'b01, 32'd9, 32'd3) || div_wb_result !== 32'd3 || div_wb_rd !== 5'd3)
      $display("[TB] FAIL %s got lat=%0d res=%h rd=%0d expected lat=%0d res=3 rd=3",
               name, lat, div_wb_result, div_wb_rd, exp_lat(2'b01, 32'd9, 32'd3));
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    wb_div_ready = 1'b1;
    issue(2'b01, 5'd9, 32'd77, 32'd5);
    repeat (8) @(negedge clk);
    wb_do_branch = 1'b1;
    @(negedge clk);
    wb_do_branch = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_wb_valid || div_ix_done) seen = 1'b1;
    end
    check_cnt++;
    if (seen !== 1'b0) $display("[TB] FAIL flush_divide got activity=%b expected 0", seen);
    else pass_cnt++;
    check_followup("after_flush_divide");

    wb_div_ready = 1'b0;
    issue(2'b01, 5'd10, 32'd77, 32'd5);
    wait_valid(lat);
    wb_div_ready = 1'b1;
    wb_do_branch = 1'b1;
    @(negedge clk);
    wb_div_ready = 1'b0;
    wb_do_branch = 1'b0;
    seen = div_ix_done;
    check_cnt++;
    if (div_wb_valid !== 1'b0) $display("[TB] FAIL flush_done_valid got %b expected 0", div_wb_valid);
    else pass_cnt++;
    repeat (5) begin
      @(negedge clk);
      if (div_ix_done || div_wb_valid) seen = 1'b1;
    end
    check_cnt++;
    if (seen !== 1'b0) $display("[TB] FAIL flush_done_nodone got activity=%b expected 0", seen);
    else pass_cnt++;
    wb_div_ready = 1'b1;
    check_followup("after_flush_done");

    ix_div_inf.div_control = DIV_OP_DIVU;
    ix_div_inf.rs1 = 32'd50;
    ix_div_inf.rs2 = 32'd7;
    ix_div_valid = 1'b1;
    wb_do_branch = 1'b1;
    @(negedge clk);
    ix_div_valid = 1'b0;
    wb_do_branch = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_wb_valid || div_ix_done) seen = 1'b1;
    end
    check_cnt++;
    if (seen !== 1'b0) $display("[TB] FAIL flush_with_issue got activity=%b expected 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int lat;
    wb_div_ready = 1'b1;
    issue(2'b01, 5'd4, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_followup("after_reset_divide");

    wb_div_ready = 1'b0;
    issue(2'b01, 5'd12, 32'd1000, 32'd3);
    wait_valid(lat);
    rst = 1'b1;
    #1;
    check_cnt++;
    if ({div_wb_valid, div_ix_done, div_wb_rd, div_wb_result} !== '0)
      $display("[TB] FAIL async_reset_done got v=%b d=%b rd=%h res=%h expected all zero",
               div_wb_valid, div_ix_done, div_wb_rd, div_wb_result);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    wb_div_ready = 1'b1;
    check_followup("after_reset_done");
  endtask

  task automatic test_back_to_back();
    int lat;
    wb_div_ready = 1'b1;
    issue(2'b01, 5'd20, 32'd200, 32'd9);
    wait_valid(lat);
    @(negedge clk);
    check_cnt++;
    if (div_ix_done !== 1'b1) $display("[TB] FAIL b2b_first_done got %b expected 1", div_ix_done);
    else pass_cnt++;
    issue(2'b11, 5'd21, 32'd200, 32'd9);
    wait_valid(lat);
    check_cnt++;
    if (lat !== exp_lat(2'b11, 32'd200, 32'd9) || div_wb_result !== 32'd2 || div_wb_rd !== 5'd21)
      $display("[TB] FAIL b2b_second got lat=%0d res=%h rd=%0d expected lat=%0d res=2 rd=21",
               lat, div_wb_result, div_wb_rd, exp_lat(2'b11, 32'd200, 32'd9));
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    ix_div_valid = 1'b0;
    ix_div_inf   = '0;
    wb_do_branch = 1'b0;
    wb_div_ready = 1'b1;
    test_reset();
    test_arith();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
